// File: rtl/video_timing_if.sv
// Raster timing bundle between the timing generator and the overlay stage.
// The master drives coordinates and controls. The slave supplies the pixel enable.
interface video_timing_if;
  logic        ce;
  logic [11:0] x;
  logic [10:0] y;
  logic        hs;
  logic        vs;
  logic        blk;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  ce,
    output x, y, hs, vs, blk, line_start, frame_start
  );

  modport slave (
    output ce,
    input  x, y, hs, vs, blk, line_start, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator that produces pixel coordinates, sync, blanking and line/frame pulses.
// Every decode is taken from the next position, so each control is registered and aligned with x/y.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  video_timing_if.master vt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] x_q;
  logic [10:0] y_q;
  logic        hs_q;
  logic        vs_q;
  logic        blk_q;
  logic        line_start_q;
  logic        frame_start_q;

  logic [11:0] x_nxt;
  logic [10:0] y_nxt;
  logic        x_wrap;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        blk_nxt;
  logic        line_start_nxt;
  logic        frame_start_nxt;

  always_comb begin
    x_wrap = (x_q == H_LAST);
    x_nxt  = x_wrap ? '0 : x_q + 12'd1;
    y_nxt  = y_q;
    if (x_wrap) begin
      y_nxt = (y_q == V_LAST) ? '0 : y_q + 11'd1;
    end
  end

  always_comb begin
    blk_nxt         = (x_nxt >= H_ACT_END) || (y_nxt >= V_ACT_END);
    hs_nxt          = ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? HS_POL : ~HS_POL;
    vs_nxt          = ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? VS_POL : ~VS_POL;
    line_start_nxt  = (x_nxt == '0);
    frame_start_nxt = (x_nxt == '0) && (y_nxt == '0);
  end

  // ce gates the whole register set, so the pulses stay frozen between enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blk_q         <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (vt.ce) begin
      x_q           <= x_nxt;
      y_q           <= y_nxt;
      hs_q          <= hs_nxt;
      vs_q          <= vs_nxt;
      blk_q         <= blk_nxt;
      line_start_q  <= line_start_nxt;
      frame_start_q <= frame_start_nxt;
    end
  end

  assign vt.x           = x_q;
  assign vt.y           = y_q;
  assign vt.hs          = hs_q;
  assign vt.vs          = vs_q;
  assign vt.blk         = blk_q;
  assign vt.line_start  = line_start_q;
  assign vt.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default 640x480 geometry plus a tiny 8x6 raster.
module tb_video_timing_gen;

  logic clk;
  logic rst_d;
  logic rst_t;
  int unsigned n_cmp;
  int unsigned n_err;

  video_timing_if if_d ();
  video_timing_if if_t ();

  video_timing_gen u_dflt (
    .clk   (clk),
    .rst_n (rst_d),
    .vt    (if_d)
  );

  video_timing_gen #(
    .H_ACTIVE (4),
    .H_FP     (1),
    .H_SYNC   (2),
    .H_BP     (1),
    .V_ACTIVE (3),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b1)
  ) u_tiny (
    .clk   (clk),
    .rst_n (rst_t),
    .vt    (if_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vectors: {x, y, hs, vs, blk, line_start, frame_start}
  logic [27:0] obs_d;
  logic [27:0] obs_t;
  assign obs_d = {if_d.x, if_d.y, if_d.hs, if_d.vs, if_d.blk, if_d.line_start, if_d.frame_start};
  assign obs_t = {if_t.x, if_t.y, if_t.hs, if_t.vs, if_t.blk, if_t.line_start, if_t.frame_start};

  // Expected state of the default raster after k enabled edges since reset release.
  function automatic logic [27:0] exp_dflt(input int unsigned k);
    int unsigned xi, yi;
    logic hs, vs, blk, ls, fs;
    xi  = k % 800;
    yi  = (k / 800) % 525;
    hs  = !((xi >= 656) && (xi < 752));
    vs  = !((yi >= 490) && (yi < 492));
    blk = !((xi < 640) && (yi < 480));
    ls  = (k > 0) && (xi == 0);
    fs  = ls && (yi == 0);
    return {12'(xi), 11'(yi), hs, vs, blk, ls, fs};
  endfunction

  // Expected state of the tiny raster (8 x 6, active-high syncs) after k enabled edges.
  function automatic logic [27:0] exp_tiny(input int unsigned k);
    int unsigned xi, yi;
    logic hs, vs, blk, ls, fs;
    xi  = k % 8;
    yi  = (k / 8) % 6;
    hs  = (xi >= 5) && (xi < 7);
    vs  = (yi == 4);
    blk = (xi >= 4) || (yi >= 3);
    ls  = (k > 0) && (xi == 0);
    fs  = ls && (yi == 0);
    return {12'(xi), 11'(yi), hs, vs, blk, ls, fs};
  endfunction

  task automatic test_reset();
    rst_d = 1'b0;
    rst_t = 1'b0;
    if_d.ce = 1'b1;
    if_t.ce = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_d !== {12'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_dflt got %h want %h", obs_d, {12'd0, 11'd0, 5'b11000});
    end
    n_cmp++;
    if (obs_t !== {12'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_tiny got %h want %h", obs_t, 28'd0);
    end
  endtask

  task automatic test_default_lines();
    logic [27:0] e;
    rst_d = 1'b1;
    for (int unsigned k = 1; k <= 2450; k++) begin
      @(negedge clk);
      e = exp_dflt(k);
      n_cmp++;
      if (obs_d !== e) begin
        n_err++;
        $display("FAIL dflt_raster k=%0d got %h want %h", k, obs_d, e);
      end
    end
  endtask

  task automatic test_tiny_frames();
    logic [27:0] e;
    int unsigned ls_cnt, fs_cnt;
    ls_cnt = 0;
    fs_cnt = 0;
    rst_t = 1'b0;
    if_t.ce = 1'b1;
    @(negedge clk);
    rst_t = 1'b1;
    for (int unsigned k = 1; k <= 96; k++) begin
      @(negedge clk);
      e = exp_tiny(k);
      n_cmp++;
      if (obs_t !== e) begin
        n_err++;
        $display("FAIL tiny_raster k=%0d got %h want %h", k, obs_t, e);
      end
      if (if_t.line_start === 1'b1) ls_cnt++;
      if (if_t.frame_start === 1'b1) fs_cnt++;
    end
    n_cmp++;
    if (ls_cnt != 12 || fs_cnt != 2) begin
      n_err++;
      $display("FAIL tiny_pulse_count got ls=%0d fs=%0d want ls=12 fs=2", ls_cnt, fs_cnt);
    end
  endtask

  task automatic test_ce_pattern();
    logic [3:0] pat;
    logic [27:0] e;
    int unsigned k, ls_cnt, fs_cnt;
    pat = 4'b1001;
    k = 0;
    ls_cnt = 0;
    fs_cnt = 0;
    rst_t = 1'b0;
    @(negedge clk);
    rst_t = 1'b1;
    for (int unsigned i = 0; i < 192; i++) begin
      if_t.ce = pat[i % 4];
      @(negedge clk);
      if (pat[i % 4]) k++;
      e = exp_tiny(k);
      n_cmp++;
      if (obs_t !== e) begin
        n_err++;
        $display("FAIL ce_freeze edge=%0d k=%0d got %h want %h", i, k, obs_t, e);
      end
      if (pat[i % 4] && if_t.line_start === 1'b1) ls_cnt++;
      if (pat[i % 4] && if_t.frame_start === 1'b1) fs_cnt++;
    end
    n_cmp++;
    if (ls_cnt != 12 || fs_cnt != 2) begin
      n_err++;
      $display("FAIL ce_pulse_count got ls=%0d fs=%0d want ls=12 fs=2", ls_cnt, fs_cnt);
    end
    if_t.ce = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [27:0] e;
    rst_t = 1'b0;
    if_t.ce = 1'b1;
    @(negedge clk);
    rst_t = 1'b1;
    repeat (19) @(negedge clk);
    n_cmp++;
    if (obs_t !== exp_tiny(19)) begin
      n_err++;
      $display("FAIL async_pre got %h want %h", obs_t, exp_tiny(19));
    end
    #2;
    rst_t = 1'b0;
    #1;
    n_cmp++;
    if (obs_t !== 28'd0) begin
      n_err++;
      $display("FAIL async_clear got %h want %h", obs_t, 28'd0);
    end
    @(negedge clk);
    rst_t = 1'b1;
    for (int unsigned k = 1; k <= 50; k++) begin
      @(negedge clk);
      e = exp_tiny(k);
      n_cmp++;
      if (obs_t !== e) begin
        n_err++;
        $display("FAIL async_restart k=%0d got %h want %h", k, obs_t, e);
      end
    end
  endtask

  task automatic test_wrap();
    rst_t = 1'b0;
    if_t.ce = 1'b1;
    @(negedge clk);
    rst_t = 1'b1;
    repeat (47) @(negedge clk);
    n_cmp++;
    if (if_t.x !== 12'd7 || if_t.y !== 11'd5) begin
      n_err++;
      $display("FAIL wrap_pre got x=%0d y=%0d want x=7 y=5", if_t.x, if_t.y);
    end
    @(negedge clk);
    n_cmp++;
    if (obs_t !== {12'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_edge got %h want %h", obs_t, {12'd0, 11'd0, 5'b00011});
    end
    @(negedge clk);
    n_cmp++;
    if (obs_t !== {12'd1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_after got %h want %h", obs_t, {12'd1, 11'd0, 5'b00000});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_default_lines();
    test_tiny_frames();
    test_ce_pattern();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
